// File: rtl/mem_wb_buffer.sv
// rtl/mem_wb_buffer.sv - MEM/WB pipeline register for the 16-bit processor
//
// Captures the write-back control bits, destination address, ALU result,
// memory read data and R0 data on every rising clk edge and presents them to
// the WB stage one cycle later. A reset edge loads a bubble (all zeros, so no
// register-file write happens).
//
// Ports:
//   clk          in   1   system clock, rising edge
//   reset        in   1   synchronous active-high reset
//   regWrite     in   1   register-file write enable
//   r0Write      in   1   R0 write enable (second write port)
//   memSource    in   1   WB mux select, 1 = DataIn, 0 = ALUResult
//   RA1          in   4   destination register address
//   ALUResult    in  16   ALU result
//   DataIn       in  16   data memory read data
//   R0D          in  16   data destined for R0
//   *_o          out      registered copy of the matching input

module mem_wb_buffer (
   input  logic        clk,
   input  logic        reset,
   input  logic        regWrite,
   input  logic        r0Write,
   input  logic        memSource,
   input  logic [3:0]  RA1,
   input  logic [15:0] ALUResult,
   input  logic [15:0] DataIn,
   input  logic [15:0] R0D,
   output logic        regWrite_o,
   output logic        r0Write_o,
   output logic        memSource_o,
   output logic [3:0]  RA1_o,
   output logic [15:0] ALUResult_o,
   output logic [15:0] DataIn_o,
   output logic [15:0] R0D_o
);

   logic        reg_write_d,  reg_write_q;
   logic        r0_write_d,   r0_write_q;
   logic        mem_source_d, mem_source_q;
   logic [3:0]  ra1_d,        ra1_q;
   logic [15:0] alu_result_d, alu_result_q;
   logic [15:0] data_in_d,    data_in_q;
   logic [15:0] r0_data_d,    r0_data_q;

   // Straight capture: no enable, stall or flush; upstream hazard logic
   // holds or zeroes the inputs when a bubble is needed.
   always_comb begin
      reg_write_d  = regWrite;
      r0_write_d   = r0Write;
      mem_source_d = memSource;
      ra1_d        = RA1;
      alu_result_d = ALUResult;
      data_in_d    = DataIn;
      r0_data_d    = R0D;
   end

   // Reset wins over capture; all-zero state is a harmless bubble.
   always_ff @(posedge clk) begin
      if (reset) begin
         reg_write_q  <= 1'b0;
         r0_write_q   <= 1'b0;
         mem_source_q <= 1'b0;
         ra1_q        <= 4'h0;
         alu_result_q <= 16'h0000;
         data_in_q    <= 16'h0000;
         r0_data_q    <= 16'h0000;
      end else begin
         reg_write_q  <= reg_write_d;
         r0_write_q   <= r0_write_d;
         mem_source_q <= mem_source_d;
         ra1_q        <= ra1_d;
         alu_result_q <= alu_result_d;
         data_in_q    <= data_in_d;
         r0_data_q    <= r0_data_d;
      end
   end

   assign regWrite_o  = reg_write_q;
   assign r0Write_o   = r0_write_q;
   assign memSource_o = mem_source_q;
   assign RA1_o       = ra1_q;
   assign ALUResult_o = alu_result_q;
   assign DataIn_o    = data_in_q;
   assign R0D_o       = r0_data_q;

endmodule

// File: tb/tb_mem_wb_buffer.sv
// tb/tb_mem_wb_buffer.sv - self-checking bench for mem_wb_buffer

module tb_mem_wb_buffer;

   typedef struct packed {
      logic        rw;
      logic        r0w;
      logic        ms;
      logic [3:0]  ra;
      logic [15:0] alu;
      logic [15:0] din;
      logic [15:0] r0d;
   } wb_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        regWrite, r0Write, memSource;
   logic [3:0]  RA1;
   logic [15:0] ALUResult, DataIn, R0D;
   logic        regWrite_o, r0Write_o, memSource_o;
   logic [3:0]  RA1_o;
   logic [15:0] ALUResult_o, DataIn_o, R0D_o;

   int tests_run = 0;
   int tests_failed = 0;

   wb_t exp_q[$];
   wb_t last_exp;

   mem_wb_buffer dut (
      .clk         (clk),
      .reset       (reset),
      .regWrite    (regWrite),
      .r0Write     (r0Write),
      .memSource   (memSource),
      .RA1         (RA1),
      .ALUResult   (ALUResult),
      .DataIn      (DataIn),
      .R0D         (R0D),
      .regWrite_o  (regWrite_o),
      .r0Write_o   (r0Write_o),
      .memSource_o (memSource_o),
      .RA1_o       (RA1_o),
      .ALUResult_o (ALUResult_o),
      .DataIn_o    (DataIn_o),
      .R0D_o       (R0D_o)
   );

   always #5 clk = ~clk;

   function automatic wb_t mk(input logic rw, input logic r0w, input logic ms,
                              input logic [3:0] ra, input logic [15:0] alu,
                              input logic [15:0] din, input logic [15:0] r0d);
      wb_t v;
      v.rw = rw; v.r0w = r0w; v.ms = ms; v.ra = ra;
      v.alu = alu; v.din = din; v.r0d = r0d;
      return v;
   endfunction

   // Drive inputs and push what the outputs must show after the next edge.
   task automatic drive(input wb_t v, input logic rst);
      wb_t e;
      reset     = rst;
      regWrite  = v.rw;
      r0Write   = v.r0w;
      memSource = v.ms;
      RA1       = v.ra;
      ALUResult = v.alu;
      DataIn    = v.din;
      R0D       = v.r0d;
      e = rst ? '0 : v;
      exp_q.push_back(e);
   endtask

   task automatic check(input string tag, input wb_t e);
      tests_run++;
      assert (regWrite_o === e.rw) else begin
         tests_failed++;
         $error("FAIL %s.regWrite_o: observed %b expected %b", tag, regWrite_o, e.rw);
      end
      tests_run++;
      assert (r0Write_o === e.r0w) else begin
         tests_failed++;
         $error("FAIL %s.r0Write_o: observed %b expected %b", tag, r0Write_o, e.r0w);
      end
      tests_run++;
      assert (memSource_o === e.ms) else begin
         tests_failed++;
         $error("FAIL %s.memSource_o: observed %b expected %b", tag, memSource_o, e.ms);
      end
      tests_run++;
      assert (RA1_o === e.ra) else begin
         tests_failed++;
         $error("FAIL %s.RA1_o: observed %h expected %h", tag, RA1_o, e.ra);
      end
      tests_run++;
      assert (ALUResult_o === e.alu) else begin
         tests_failed++;
         $error("FAIL %s.ALUResult_o: observed %h expected %h", tag, ALUResult_o, e.alu);
      end
      tests_run++;
      assert (DataIn_o === e.din) else begin
         tests_failed++;
         $error("FAIL %s.DataIn_o: observed %h expected %h", tag, DataIn_o, e.din);
      end
      tests_run++;
      assert (R0D_o === e.r0d) else begin
         tests_failed++;
         $error("FAIL %s.R0D_o: observed %h expected %h", tag, R0D_o, e.r0d);
      end
   endtask

   // One rising edge, then sample 1 time unit later and pop the scoreboard.
   task automatic step(input string tag);
      @(posedge clk);
      #1;
      tests_run++;
      assert (exp_q.size() > 0) else begin
         tests_failed++;
         $error("FAIL %s.scoreboard: observed empty expected entry", tag);
      end
      if (exp_q.size() > 0) begin
         last_exp = exp_q.pop_front();
         check(tag, last_exp);
      end
   endtask

   initial begin
      wb_t ones, v;
      wb_t stream[8];

      // Reset clear with all-ones inputs
      ones = '1;
      drive(ones, 1'b1);
      step("reset_clear");

      // Basic capture; outputs must not change before the edge
      drive(mk(1'b1, 1'b1, 1'b1, 4'h1, 16'h0001, 16'h0001, 16'h0001), 1'b0);
      #2;
      check("basic_before_edge", last_exp);
      step("basic_capture");

      // Mid-cycle input change must not leak through
      #3;
      v = mk(1'b1, 1'b1, 1'b1, 4'hF, 16'hBEEF, 16'h0001, 16'h0001);
      drive(v, 1'b0);
      #1;
      check("hold_mid_cycle", last_exp);
      step("hold_update");

      // Field independence
      drive(mk(1'b1, 1'b0, 1'b1, 4'hA, 16'h1234, 16'h5678, 16'h9ABC), 1'b0);
      step("field_indep");
      drive(mk(1'b0, 1'b1, 1'b0, 4'h5, 16'hA5A5, 16'h0FF0, 16'h8001), 1'b0);
      step("field_indep2");

      // Reset priority with non-zero inputs, then immediate recovery
      drive(mk(1'b1, 1'b1, 1'b1, 4'h7, 16'hCAFE, 16'hF00D, 16'h1357), 1'b1);
      step("reset_priority");
      drive(mk(1'b1, 1'b1, 1'b1, 4'h7, 16'hCAFE, 16'hF00D, 16'h1357), 1'b0);
      step("reset_recover");

      // Back-to-back stream, new inputs every cycle
      for (int i = 0; i < 8; i++) begin
         stream[i] = mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 4'(i + 3),
                        16'($urandom), 16'($urandom), 16'($urandom));
         drive(stream[i], 1'b0);
         step($sformatf("stream%0d", i));
      end

      // Reset mid-stream discards the in-flight entry
      drive(mk(1'b1, 1'b0, 1'b1, 4'hC, 16'h4242, 16'h2424, 16'h7777), 1'b1);
      step("reset_midstream");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/mem_wb_buffer.md
# mem_wb_buffer

Pipeline register between the MEM and WB stages of the 16-bit processor. It samples the write-back control bits, destination register address, ALU result, memory read data and R0 data on each rising clock edge, and presents them to the write-back stage one cycle later. Synchronous reset clears the stage, which acts as a bubble: no register writes occur.

## Interface
Parameters: none. Widths are fixed at 16-bit data and a 4-bit register address.

Ports, in positional order (instantiation is positional):
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset; one clock; no asynchronous path
- regWrite  in  1  MEM-stage register-file write enable
- r0Write  in  1  MEM-stage R0 write enable (second write port, e.g. for multiply/divide results)
- memSource  in  1  write-back mux select; 1 = memory data (DataIn), 0 = ALUResult
- RA1  in  4  destination register address
- ALUResult  in  16  ALU result from MEM stage
- DataIn  in  16  data read from data memory
- R0D  in  16  data destined for R0
- regWrite_o  out  1  registered regWrite
- r0Write_o  out  1  registered r0Write
- memSource_o  out  1  registered memSource
- RA1_o  out  4  registered RA1
- ALUResult_o  out  16  registered ALUResult
- DataIn_o  out  16  registered DataIn
- R0D_o  out  16  registered R0D

## Operation
- Each output is a dedicated flip-flop bank driven by its matching input. There is no combinational path from input to output.
- On a rising clk edge with reset=1, every output loads 0: regWrite_o, r0Write_o and memSource_o = 0; RA1_o = 4'h0; ALUResult_o, DataIn_o and R0D_o = 16'h0000.
- On a rising clk edge with reset=0, every output loads its input value unchanged. No muxing, sign extension or arithmetic is applied; widths match exactly.
- The block has no enable, stall or flush input. It captures every cycle. Hazard handling upstream must hold or zero the inputs as needed.
- Reset takes priority over data capture in the same cycle.
- Output values before the first clock edge are undefined (X in simulation) until a reset edge or capture edge occurs. An implementation may add an initial value of 0 for simulation only; synthesis must not depend on it.

## Timing
- Latency is exactly 1 cycle. An input sampled at rising edge N appears on the outputs immediately after edge N and holds until edge N+1.
- Inputs may change at any time between edges. Only the value present at the rising edge (subject to setup and hold) is captured.
- Reset asserted mid-stream: at the next rising edge the outputs go to 0, and in-flight data in this stage is discarded.
- Reset deasserted: at the first edge with reset=0, the outputs take the current inputs. There is no extra recovery cycle.
- All outputs update together on the same edge. No field may lag another.

## Test plan
- Reset clear: preload all inputs to all-ones, hold reset=1 across one rising edge -> every output is 0 (RA1_o=0, 16-bit outputs=16'h0000, control bits=0).
- Basic capture: reset=0; regWrite=r0Write=memSource=1, RA1=1, ALUResult=DataIn=R0D=16'h0001; apply one edge -> outputs equal the inputs after that edge, not before it.
- Hold between edges: change the inputs to RA1=4'hF and ALUResult=16'hBEEF midway between edges -> outputs keep the previous values until the next rising edge, then update.
- Field independence: drive distinct patterns (RA1=4'hA, ALUResult=16'h1234, DataIn=16'h5678, R0D=16'h9ABC, regWrite=1, r0Write=0, memSource=1) -> each output matches its own input, with no cross-wiring.
- Reset priority: reset=1 with non-zero inputs for one edge, then reset=0 -> outputs read 0 after the reset edge and the input values after the following edge.
- Back-to-back stream: change the inputs every cycle for 8 cycles -> each output sequence equals the input sequence delayed by exactly one cycle.
